// File: rtl/grid_pkg.sv
// Shared types and constants for the LED-matrix grid scanner.
package grid_pkg;

    localparam int unsigned GRID_ROWS = 8;
    localparam int unsigned GRID_COLS = 8;

    typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module scan_timer
    import grid_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         clr_i,
    input  logic [W-1:0] load_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;

    // done is precomputed so it is valid in the same cycle the count reaches zero
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (clr_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (start_i) begin
            cnt_d  = load_i;
            done_d = (load_i == '0);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - W'(1);
            done_d = (cnt_q == W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/grid_row_scanner.sv
// Snapshots the engine grid at frame boundaries and scans it onto an LED matrix row by row.
// Define GRID_SCAN_ACTIVE_LOW_EN for an inverted (common-anode) row/column drive.
module grid_row_scanner
    import grid_pkg::*;
#(
    parameter int unsigned ROWS  = GRID_ROWS,
    parameter int unsigned COLS  = GRID_COLS,
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 grid_valid,
    output logic                 grid_ack,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_start
);

    localparam int unsigned GW   = ROWS * COLS;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

`ifdef GRID_SCAN_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif
    localparam logic [ROWS-1:0] ROW_OFF = {ROWS{POL}};
    localparam logic [COLS-1:0] COL_OFF = {COLS{POL}};

    scan_state_t       state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [GW-1:0]     stage_q, stage_d;
    logic [GW-1:0]     buf_q, buf_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    logic              fs_q, fs_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic [COLS-1:0]   col_q, col_d;

    logic              boundary_c;
    logic              tmr_start_c;
    logic              tmr_clr_c;
    logic [TW-1:0]     tmr_load_c;
    logic              tmr_done;

    scan_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (reset),
        .start_i (tmr_start_c),
        .clr_i   (tmr_clr_c),
        .load_i  (tmr_load_c),
        .done_o  (tmr_done)
    );

    // Next-state, buffer handoff and output computation
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        stage_d     = stage_q;
        buf_d       = buf_q;
        pend_d      = pend_q;
        ack_d       = 1'b0;
        fs_d        = 1'b0;
        boundary_c  = 1'b0;
        tmr_start_c = 1'b0;
        tmr_clr_c   = 1'b0;
        tmr_load_c  = '0;

        if (grid_valid) begin
            stage_d = grid;
            pend_d  = 1'b1;
        end

        if (!enable) begin
            state_d   = grid_pkg::IDLE;
            row_d     = '0;
            tmr_clr_c = 1'b1;
        end else begin
            case (state_q)
                grid_pkg::IDLE: begin
                    state_d     = grid_pkg::BLANK;
                    row_d       = '0;
                    boundary_c  = 1'b1;
                    tmr_start_c = 1'b1;
                    tmr_load_c  = TW'(BLANK - 1);
                end
                grid_pkg::BLANK: begin
                    if (tmr_done) begin
                        state_d     = grid_pkg::DRIVE;
                        tmr_start_c = 1'b1;
                        tmr_load_c  = TW'(DWELL - 1);
                    end
                end
                grid_pkg::DRIVE: begin
                    if (tmr_done) begin
                        state_d     = grid_pkg::BLANK;
                        tmr_start_c = 1'b1;
                        tmr_load_c  = TW'(BLANK - 1);
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d      = '0;
                            boundary_c = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = grid_pkg::IDLE;
                    row_d   = '0;
                end
            endcase
        end

        // A strobe on the boundary cycle itself bypasses staging
        if (boundary_c) begin
            fs_d = 1'b1;
            if (grid_valid) begin
                buf_d  = grid;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end else if (pend_q) begin
                buf_d  = stage_q;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end
        end

        if (state_d == grid_pkg::DRIVE) begin
            row_sel_d = ROW_OFF ^ (ROWS'(1) << row_d);
            col_d     = COL_OFF ^ buf_d[int'(row_d)*COLS +: COLS];
        end else begin
            row_sel_d = ROW_OFF;
            col_d     = COL_OFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= grid_pkg::IDLE;
            row_q     <= '0;
            stage_q   <= '0;
            buf_q     <= '0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
            row_sel_q <= ROW_OFF;
            col_q     <= COL_OFF;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            stage_q   <= stage_d;
            buf_q     <= buf_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            fs_q      <= fs_d;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
        end
    end

    assign grid_ack    = ack_q;
    assign frame_start = fs_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_q;

endmodule

// File: tb/tb_grid_row_scanner.sv
// Directed bench for grid_row_scanner with DWELL=4, BLANK=1 (40-cycle frames).
module tb_grid_row_scanner;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned DWELL = 4;
    localparam int unsigned BLANK = 1;

`ifdef GRID_SCAN_ACTIVE_LOW_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    localparam logic [63:0] DIAG = 64'h8040201008040201;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] PAT_A = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] PAT_5 = 64'h5555555555555555;
    localparam logic [63:0] MIX  = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] grid;
    logic        grid_valid;
    logic        grid_ack;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

    grid_row_scanner #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .grid        (grid),
        .grid_valid  (grid_valid),
        .grid_ack    (grid_ack),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_off(input string tag, input logic exp_fs, input logic exp_ack);
        check_eq({tag, " row_sel"}, 64'(row_sel), 64'(INV));
        check_eq({tag, " col_data"}, 64'(col_data), 64'(INV));
        check_eq({tag, " frame_start"}, 64'(frame_start), 64'(exp_fs));
        check_eq({tag, " grid_ack"}, 64'(grid_ack), 64'(exp_ack));
    endtask

    task automatic check_drive(input string tag, input int r, input logic [7:0] exp_col);
        logic [7:0] one;
        one = 8'h01;
        check_eq({tag, " row_sel"}, 64'(row_sel), 64'((one << r) ^ INV));
        check_eq({tag, " col_data"}, 64'(col_data), 64'(exp_col ^ INV));
    endtask

    // Starts on frame cycle 0 and ends on cycle 0 of the next frame; ic1/ic2 inject strobes
    task automatic run_frame(input logic [63:0] g, input logic exp_ack,
                             input int ic1, input logic [63:0] ig1,
                             input int ic2, input logic [63:0] ig2);
        int c;
        c = 0;
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 5; p++) begin
                if (p == 0) begin
                    check_off($sformatf("blank r%0d", r), (r == 0), (r == 0) ? exp_ack : 1'b0);
                end else begin
                    check_drive($sformatf("drive r%0d", r), r, g[8*r +: 8]);
                    check_eq($sformatf("ack mid r%0d", r), 64'(grid_ack), 64'd0);
                end
                grid_valid = (c == ic1) || (c == ic2);
                if (c == ic1) grid = ig1;
                else if (c == ic2) grid = ig2;
                step();
                grid_valid = 1'b0;
                c++;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        grid       = '0;
        grid_valid = 1'b0;
        #2;
        check_off("reset", 1'b0, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check_off("idle", 1'b0, 1'b0);

        // First frame: strobe on the IDLE->BLANK cycle goes straight into the buffer
        enable     = 1'b1;
        grid       = DIAG;
        grid_valid = 1'b1;
        step();
        grid_valid = 1'b0;
        run_frame(DIAG, 1'b1, 10, ONES, -1, '0);
        run_frame(ONES, 1'b1, 5, PAT_A, 20, PAT_5);
        run_frame(PAT_5, 1'b1, 39, MIX, -1, '0);
        run_frame(MIX, 1'b1, -1, '0, -1, '0);

        // Frame 5 boundary: nothing pending after the bypass
        check_off("f5 boundary", 1'b1, 1'b0);
        repeat (17) step();
        check_drive("row3 before disable", 3, 8'h89);
        enable = 1'b0;
        step();
        check_off("disabled", 1'b0, 1'b0);
        repeat (3) step();
        check_off("idle hold", 1'b0, 1'b0);
        enable = 1'b1;
        step();
        check_off("restart", 1'b1, 1'b0);
        step();
        check_drive("restart row0", 0, 8'hEF);

        // Stage a grid, then reset between edges: outputs clear at once and the stage is lost
        grid       = ONES;
        grid_valid = 1'b1;
        step();
        grid_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_off("async reset", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check_off("post reset boundary", 1'b1, 1'b0);
        step();
        check_drive("post reset row0", 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grid_row_scanner.md
Name: grid_row_scanner

Overview:
- Reader-side consumer of the 64-bit life grid produced by the generation engine.
- Captures a tear-free snapshot of the grid and drives an 8x8 LED matrix one row at a time.
- Row r of the grid is bits grid[8r+7:8r]; column c of row r is grid[8r+c].
- Sits between the engine's grid output and the board matrix pins.

Parameters:
- ROWS, 8, number of matrix rows scanned.
- COLS, 8, columns per row; grid width = ROWS*COLS.
- DWELL, 1000, clk cycles each row is driven.
- BLANK, 2, clk cycles all outputs are off before each row (anti-ghosting); must be >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  scan runs while high.
- grid  input  ROWS*COLS  current generation from the engine.
- grid_valid  input  1  one-cycle strobe: grid holds a new generation this cycle.
- grid_ack  output  1  one-cycle pulse: staged grid copied into the display buffer.
- row_sel  output  ROWS  one-hot row drive.
- col_data  output  COLS  column data for the driven row.
- frame_start  output  1  one-cycle pulse on the first BLANK cycle of row 0.

Behaviour:
- Reset values: row_sel=0, col_data=0, grid_ack=0, frame_start=0; stage, display buffer, row index, timer=0; pending=0; state IDLE.
- Staging: on any cycle with grid_valid=1, stage<=grid and pending<=1. A later strobe overwrites an earlier one; last generation wins.
- FSM states:
  - IDLE: outputs 0, row=0. enable=1 moves to BLANK (row 0) on the next edge.
  - BLANK: row_sel=0 and col_data=0 for BLANK cycles, then DRIVE.
  - DRIVE: row_sel=1<<row, col_data=buffer row, for DWELL cycles. Then row=row+1 and BLANK.
- Row wrap: after row ROWS-1, the next row is 0. Entering BLANK for row 0 is the frame boundary.
- Frame boundary (from IDLE or after the wrap):
  - If pending: buffer<=stage, pending<=0, grid_ack=1 for that cycle.
  - frame_start=1 for that cycle.
  - grid_valid on the boundary cycle itself: grid goes straight into the buffer (bypass), pending stays 0, grid_ack=1.
- Frame length is ROWS*(BLANK+DWELL) cycles. The buffer never changes mid-frame.
- enable=0 in any state: IDLE on the next edge. Outputs are 0 from that edge on, row and timer reset. stage and pending are kept.
- reset mid-frame: outputs 0 asynchronously; pending lost.
- Outputs are registered, so changes appear one edge after the state change that causes them.

Optional Feature:
- GRID_SCAN_ACTIVE_LOW_EN:
  - Defined: row_sel and col_data are driven inverted (common-anode matrix). Reset, IDLE and BLANK values are all-ones. grid_ack and frame_start are unaffected.
  - Undefined: active-high as above.

Decomposition:
- grid_pkg holds:
  - GRID_ROWS=8 and GRID_COLS=8 constants.
  - typedef grid_t (logic [63:0]).
  - enum scan_state_t {IDLE, BLANK, DRIVE}.
- One sub-module, scan_timer:
  - Loadable down-counter with load value and start inputs; asserts done on the terminal count.
  - The FSM loads it with BLANK-1 or DWELL-1.

Test Plan (DWELL=4, BLANK=1, frame 40 cycles):
- Reset, enable=1, grid=64'h8040201008040201 with grid_valid on cycle 0:
  - grid_ack and frame_start pulse together.
  - Rows drive row_sel 01,02,..,80 with col_data 01,02,..,80, each for 4 cycles after 1 blank cycle.
- grid_valid mid-frame with grid=all-ones:
  - Current frame still shows the diagonal.
  - Next frame_start coincides with grid_ack; col_data=FF for every row.
- Two strobes in one frame (grid AAAA.., then 5555..):
  - One grid_ack only.
  - Next frame shows 55 on every row.
- grid_valid exactly on the boundary cycle: that grid is displayed in the starting frame; no grid_ack in the following frame.
- enable dropped during row 3 DRIVE:
  - Outputs are 0 next cycle.
  - Re-enable restarts at row 0 with a frame_start pulse.
- reset asserted mid-DRIVE, asynchronously between edges: row_sel and col_data go to 0 before the next edge; with GRID_SCAN_ACTIVE_LOW_EN defined they go to FF.
